// File: rtl/time_set_ctrl_if.sv
// Interface bundling the button inputs, the live clock time and the
// edited/committed time outputs of time_set_ctrl.
interface time_set_ctrl_if;
    logic        btn_mode;
    logic        btn_up;
    logic        btn_down;
    logic [11:0] cur_year;
    logic [4:0]  cur_month;
    logic [7:0]  cur_day;
    logic [4:0]  cur_hour;
    logic [5:0]  cur_min;
    logic [5:0]  cur_sec;
    logic [11:0] set_year;
    logic [4:0]  set_month;
    logic [7:0]  set_day;
    logic [4:0]  set_hour;
    logic [5:0]  set_min;
    logic [5:0]  set_sec;
    logic        set_load;
    logic        edit_active;
    logic [2:0]  edit_field;

    modport slave (
        input  btn_mode, btn_up, btn_down,
        input  cur_year, cur_month, cur_day, cur_hour, cur_min, cur_sec,
        output set_year, set_month, set_day, set_hour, set_min, set_sec,
        output set_load, edit_active, edit_field
    );

    modport master (
        output btn_mode, btn_up, btn_down,
        output cur_year, cur_month, cur_day, cur_hour, cur_min, cur_sec,
        input  set_year, set_month, set_day, set_hour, set_min, set_sec,
        input  set_load, edit_active, edit_field
    );
endinterface

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: debounces mode/up/down buttons and edits a shadow copy of
// the date/time field by field (year..sec), committing it with a one-cycle
// set_load strobe. Optional auto-repeat on held up/down: macro AUTOREPEAT_EN.
module time_set_ctrl #(
    parameter int unsigned DEB_CNT  = 1_000_000,
    parameter int unsigned HOLD_CNT = 50_000_000,
    parameter int unsigned RPT_CNT  = 10_000_000
) (
    input  logic           clk,
    input  logic           reset,
    time_set_ctrl_if.slave bus
);
    localparam int unsigned DW = $clog2(DEB_CNT + 1);

    typedef enum logic [2:0] {
        IDLE, E_YEAR, E_MONTH, E_DAY, E_HOUR, E_MIN, E_SEC, COMMIT
    } state_t;

    function automatic logic [7:0] dim_of(input logic [4:0] m);
        case (m)
            5'd4, 5'd6, 5'd9, 5'd11: return 8'd30;
            5'd2:                    return 8'd28;
            default:                 return 8'd31;
        endcase
    endfunction

    // bit 0 = mode, bit 1 = up, bit 2 = down
    logic [2:0]    w_raw, r_sync1, r_sync2, r_deb, r_deb_d, r_press;
    logic [DW-1:0] r_deb_cnt [3];
    state_t        r_state, w_state;
    logic [11:0]   r_year, w_year;
    logic [4:0]    r_month, w_month, r_hour, w_hour;
    logic [7:0]    r_day, w_day;
    logic [5:0]    r_min, w_min, r_sec, w_sec;
    logic          r_load, r_active;
    logic [2:0]    r_field, w_field;
    logic          w_rpt, w_up, w_dn, w_inc, w_dec, w_mode, w_editing;
    logic [4:0]    w_cap_month, w_mon_step;
    logic [7:0]    w_cap_dim, w_mon_dim, w_cur_dim;

    assign w_raw = {bus.btn_down, bus.btn_up, bus.btn_mode};

    // Synchronise, debounce and edge-detect the three buttons
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_deb_d <= '0;
            r_press <= '0;
            for (int unsigned i = 0; i < 3; i++) r_deb_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            r_press <= r_deb & ~r_deb_d;
            for (int unsigned i = 0; i < 3; i++) begin
                if (r_sync2[i] != r_deb[i]) begin
                    if (r_deb_cnt[i] == DW'(DEB_CNT - 1)) begin
                        r_deb[i]     <= r_sync2[i];
                        r_deb_cnt[i] <= '0;
                    end else begin
                        r_deb_cnt[i] <= r_deb_cnt[i] + DW'(1);
                    end
                end else begin
                    r_deb_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_editing = (r_state != IDLE) && (r_state != COMMIT);

`ifdef AUTOREPEAT_EN
    localparam int unsigned RW = $clog2(((HOLD_CNT > RPT_CNT) ? HOLD_CNT : RPT_CNT) + 1);
    logic [RW-1:0] r_rpt_cnt;
    logic          r_rpt_phase;
    logic          w_rpt_clr;

    // Only a single held up/down key in an edit field keeps the timer running
    assign w_rpt_clr = !(r_deb[1] ^ r_deb[2]) || !w_editing || r_press[1] || r_press[2];
    assign w_rpt = !w_rpt_clr &&
                   (r_rpt_phase ? (r_rpt_cnt == RW'(RPT_CNT - 1))
                                : (r_rpt_cnt == RW'(HOLD_CNT - 1)));

    // Hold/repeat timer measured from the press pulse
    always_ff @(posedge clk) begin
        if (reset || w_rpt_clr) begin
            r_rpt_cnt   <= '0;
            r_rpt_phase <= 1'b0;
        end else if (w_rpt) begin
            r_rpt_cnt   <= '0;
            r_rpt_phase <= 1'b1;
        end else begin
            r_rpt_cnt <= r_rpt_cnt + RW'(1);
        end
    end
`else
    // Repeat disabled; the hold/repeat periods have no effect in this build
    assign w_rpt = 1'b0 & (HOLD_CNT != 0) & (RPT_CNT != 0);
`endif

    assign w_mode = r_press[0];
    assign w_up   = r_press[1] | (w_rpt & r_deb[1]);
    assign w_dn   = r_press[2] | (w_rpt & r_deb[2]);
    assign w_inc  = w_up & ~w_dn;
    assign w_dec  = w_dn & ~w_up;

    assign w_cap_month = (bus.cur_month == 5'd0) ? 5'd1 :
                         (bus.cur_month > 5'd12) ? 5'd12 : bus.cur_month;
    assign w_cap_dim   = dim_of(w_cap_month);
    assign w_mon_step  = w_inc ? ((r_month == 5'd12) ? 5'd1 : r_month + 5'd1)
                               : ((r_month == 5'd1) ? 5'd12 : r_month - 5'd1);
    assign w_mon_dim   = dim_of(w_mon_step);
    assign w_cur_dim   = dim_of(r_month);

    // Next state, shadow update and next registered outputs
    always_comb begin
        w_state = r_state;
        w_year  = r_year;
        w_month = r_month;
        w_day   = r_day;
        w_hour  = r_hour;
        w_min   = r_min;
        w_sec   = r_sec;
        case (r_state)
            IDLE: begin
                if (w_mode) begin
                    w_year  = (bus.cur_year < 12'd2000) ? 12'd2000 :
                              (bus.cur_year > 12'd2099) ? 12'd2099 : bus.cur_year;
                    w_month = w_cap_month;
                    w_day   = (bus.cur_day == 8'd0) ? 8'd1 :
                              (bus.cur_day > w_cap_dim) ? w_cap_dim : bus.cur_day;
                    w_hour  = (bus.cur_hour > 5'd23) ? 5'd23 : bus.cur_hour;
                    w_min   = (bus.cur_min > 6'd59) ? 6'd59 : bus.cur_min;
                    w_sec   = (bus.cur_sec > 6'd59) ? 6'd59 : bus.cur_sec;
                    w_state = E_YEAR;
                end
            end
            COMMIT: w_state = IDLE;
            default: begin
                if (w_mode) begin
                    w_state = state_t'(r_state + 3'd1);
                end else if (w_inc | w_dec) begin
                    case (r_state)
                        E_YEAR: w_year = w_inc ? ((r_year == 12'd2099) ? 12'd2000 : r_year + 12'd1)
                                               : ((r_year == 12'd2000) ? 12'd2099 : r_year - 12'd1);
                        E_MONTH: begin
                            w_month = w_mon_step;
                            if (r_day > w_mon_dim) w_day = w_mon_dim;
                        end
                        E_DAY:  w_day = w_inc ? ((r_day == w_cur_dim) ? 8'd1 : r_day + 8'd1)
                                              : ((r_day == 8'd1) ? w_cur_dim : r_day - 8'd1);
                        E_HOUR: w_hour = w_inc ? ((r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1)
                                               : ((r_hour == 5'd0) ? 5'd23 : r_hour - 5'd1);
                        E_MIN:  w_min = w_inc ? ((r_min == 6'd59) ? 6'd0 : r_min + 6'd1)
                                              : ((r_min == 6'd0) ? 6'd59 : r_min - 6'd1);
                        E_SEC:  w_sec = w_inc ? ((r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1)
                                              : ((r_sec == 6'd0) ? 6'd59 : r_sec - 6'd1);
                        default: ;
                    endcase
                end
            end
        endcase
        w_field = 3'd7;
        if ((w_state != IDLE) && (w_state != COMMIT)) w_field = w_state - 3'd1;
    end

    // State, shadow and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_year   <= 12'd2024;
            r_month  <= 5'd1;
            r_day    <= 8'd1;
            r_hour   <= '0;
            r_min    <= '0;
            r_sec    <= '0;
            r_load   <= 1'b0;
            r_active <= 1'b0;
            r_field  <= 3'd7;
        end else begin
            r_state  <= w_state;
            r_year   <= w_year;
            r_month  <= w_month;
            r_day    <= w_day;
            r_hour   <= w_hour;
            r_min    <= w_min;
            r_sec    <= w_sec;
            r_load   <= (w_state == COMMIT);
            r_active <= (w_state != IDLE) && (w_state != COMMIT);
            r_field  <= w_field;
        end
    end

    assign bus.set_year    = r_year;
    assign bus.set_month   = r_month;
    assign bus.set_day     = r_day;
    assign bus.set_hour    = r_hour;
    assign bus.set_min     = r_min;
    assign bus.set_sec     = r_sec;
    assign bus.set_load    = r_load;
    assign bus.edit_active = r_active;
    assign bus.edit_field  = r_field;
endmodule

// File: tb/tb_time_set_ctrl.sv
// Testbench for time_set_ctrl: behavioural reference model checked every
// cycle, plus literal expectations at key points of the scenario.
module tb_time_set_ctrl;
    localparam int DEB = 4;
`ifdef AUTOREPEAT_EN
    localparam int HOLD = 20;
    localparam int RPT  = 8;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    time_set_ctrl_if bus();

`ifdef AUTOREPEAT_EN
    time_set_ctrl #(.DEB_CNT(DEB), .HOLD_CNT(HOLD), .RPT_CNT(RPT)) dut (.clk(clk), .reset(reset), .bus(bus));
`else
    time_set_ctrl #(.DEB_CNT(DEB)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_valid = 1'b0;
    int m_st;            // -1 idle, 0..5 editing field, 6 commit
    int m_sh [6];        // year, month, day, hour, min, sec
    bit m_deb [3];
    bit m_rose [3];
    bit m_press [3];
    bit m_hist [3][DEB+2];
    int m_age;

    function automatic int dim_of(input int m);
        if (m == 2) return 28;
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    function automatic int wrapf(input int v, input int lo, input int n, input int d);
        return lo + ((v - lo + d + n) % n);
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    always @(posedge clk) begin : model
        bit p [3];
        bit raw [3];
        bit rpt, u, dn, all_diff;
        int d;
        raw[0] = bus.btn_mode;
        raw[1] = bus.btn_up;
        raw[2] = bus.btn_down;
        if (reset) begin
            m_valid = 1'b1;
            m_st = -1;
            m_sh = '{2024, 1, 1, 0, 0, 0};
            m_age = 0;
            for (int b = 0; b < 3; b++) begin
                m_deb[b] = 0; m_rose[b] = 0; m_press[b] = 0;
                for (int j = 0; j < DEB + 2; j++) m_hist[b][j] = 0;
            end
        end else if (m_valid) begin
            p = m_press;
            rpt = 0;
`ifdef AUTOREPEAT_EN
            if (p[1] || p[2] || !(m_deb[1] ^ m_deb[2]) || !(m_st >= 0 && m_st <= 5)) m_age = 0;
            else begin
                m_age++;
                rpt = (m_age == HOLD) || (m_age > HOLD && (m_age - HOLD) % RPT == 0);
            end
`endif
            u  = p[1] | (rpt & m_deb[1]);
            dn = p[2] | (rpt & m_deb[2]);
            if (m_st == 6) m_st = -1;
            else if (p[0]) begin
                if (m_st < 0) begin
                    m_sh[0] = clampi(int'(bus.cur_year), 2000, 2099);
                    m_sh[1] = clampi(int'(bus.cur_month), 1, 12);
                    m_sh[2] = clampi(int'(bus.cur_day), 1, dim_of(m_sh[1]));
                    m_sh[3] = clampi(int'(bus.cur_hour), 0, 23);
                    m_sh[4] = clampi(int'(bus.cur_min), 0, 59);
                    m_sh[5] = clampi(int'(bus.cur_sec), 0, 59);
                    m_st = 0;
                end else m_st++;
            end else if (m_st >= 0 && u != dn) begin
                d = u ? 1 : -1;
                case (m_st)
                    0: m_sh[0] = wrapf(m_sh[0], 2000, 100, d);
                    1: begin
                        m_sh[1] = wrapf(m_sh[1], 1, 12, d);
                        if (m_sh[2] > dim_of(m_sh[1])) m_sh[2] = dim_of(m_sh[1]);
                    end
                    2: m_sh[2] = wrapf(m_sh[2], 1, dim_of(m_sh[1]), d);
                    3: m_sh[3] = wrapf(m_sh[3], 0, 24, d);
                    4: m_sh[4] = wrapf(m_sh[4], 0, 60, d);
                    default: m_sh[5] = wrapf(m_sh[5], 0, 60, d);
                endcase
            end
            // debounced level follows a window of DEB synchronised samples
            m_press = m_rose;
            for (int b = 0; b < 3; b++) begin
                for (int j = DEB + 1; j > 0; j--) m_hist[b][j] = m_hist[b][j-1];
                m_hist[b][0] = raw[b];
                all_diff = 1;
                for (int j = 2; j < DEB + 2; j++) if (m_hist[b][j] == m_deb[b]) all_diff = 0;
                m_rose[b] = all_diff && !m_deb[b];
                if (all_diff) m_deb[b] = !m_deb[b];
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int load_cnt = 0;
    int ld [6];

    always @(negedge clk) begin
        if (m_valid) begin
            check("set_year",    int'(bus.set_year),    m_sh[0]);
            check("set_month",   int'(bus.set_month),   m_sh[1]);
            check("set_day",     int'(bus.set_day),     m_sh[2]);
            check("set_hour",    int'(bus.set_hour),    m_sh[3]);
            check("set_min",     int'(bus.set_min),     m_sh[4]);
            check("set_sec",     int'(bus.set_sec),     m_sh[5]);
            check("set_load",    int'(bus.set_load),    (m_st == 6) ? 1 : 0);
            check("edit_active", int'(bus.edit_active), (m_st >= 0 && m_st <= 5) ? 1 : 0);
            check("edit_field",  int'(bus.edit_field),  (m_st >= 0 && m_st <= 5) ? m_st : 7);
            if (bus.set_load === 1'b1) begin
                load_cnt++;
                ld = '{int'(bus.set_year), int'(bus.set_month), int'(bus.set_day),
                       int'(bus.set_hour), int'(bus.set_min), int'(bus.set_sec)};
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit m, input bit u, input bit d, input int hold);
        bus.btn_mode = m;
        bus.btn_up   = u;
        bus.btn_down = d;
        tick(hold);
        bus.btn_mode = 1'b0;
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        tick(12);
    endtask

    task automatic set_cur(input int y, input int mo, input int d, input int h, input int mi, input int s);
        bus.cur_year  = 12'(y);
        bus.cur_month = 5'(mo);
        bus.cur_day   = 8'(d);
        bus.cur_hour  = 5'(h);
        bus.cur_min   = 6'(mi);
        bus.cur_sec   = 6'(s);
    endtask

    initial begin
        bus.btn_mode = 1'b0;
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        set_cur(2025, 2, 28, 23, 59, 59);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("rst_year",  int'(bus.set_year), 2024);
        check("rst_month", int'(bus.set_month), 1);
        check("rst_day",   int'(bus.set_day), 1);
        check("rst_hms",   int'(bus.set_hour) + int'(bus.set_min) + int'(bus.set_sec), 0);
        check("rst_load",  int'(bus.set_load), 0);
        check("rst_field", int'(bus.edit_field), 7);

        // glitch shorter than the debounce window
        bus.btn_up = 1'b1;
        tick(3);
        bus.btn_up = 1'b0;
        tick(12);
        check("glitch_field", int'(bus.edit_field), 7);
        check("glitch_year",  int'(bus.set_year), 2024);

        // capture 2025/02/28 23:59:59
        press(1, 0, 0, 8);
        check("cap_field", int'(bus.edit_field), 0);
        check("cap_year",  int'(bus.set_year), 2025);
        check("cap_month", int'(bus.set_month), 2);
        check("cap_day",   int'(bus.set_day), 28);
        check("cap_hour",  int'(bus.set_hour), 23);
        check("cap_min",   int'(bus.set_min), 59);
        check("cap_sec",   int'(bus.set_sec), 59);
        check("model_cap_year", m_sh[0], 2025);

        press(1, 0, 0, 8);              // month
        press(1, 0, 0, 8);              // day
        press(0, 1, 0, 8);              // 28 -> 1 in February
        check("day_wrap", int'(bus.set_day), 1);
        press(0, 1, 1, 8);              // up+down together: ignored
        check("updown_ignored", int'(bus.set_day), 1);
        press(1, 0, 0, 8);              // hour
        press(0, 1, 0, 8);              // 23 -> 0
        check("hour_wrap", int'(bus.set_hour), 0);
        check("model_hour_wrap", m_sh[3], 0);
        press(1, 0, 0, 8);              // min
        press(0, 1, 0, 8);              // 59 -> 0
        press(0, 0, 1, 8);              // 0 -> 59
        check("min_wrap", int'(bus.set_min), 59);

        // reset mid-edit abandons the shadow without a load
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        check("abort_year",  int'(bus.set_year), 2024);
        check("abort_field", int'(bus.edit_field), 7);
        check("abort_load",  load_cnt, 0);

        // month change clamps the day, then commit
        set_cur(2025, 1, 31, 0, 0, 0);
        press(1, 0, 0, 8);              // year
        press(1, 0, 0, 8);              // month
        press(0, 1, 0, 8);
        check("clamp_month", int'(bus.set_month), 2);
        check("clamp_day",   int'(bus.set_day), 28);
        press(1, 0, 0, 8);              // day
        press(1, 0, 0, 8);              // hour
        press(1, 0, 0, 8);              // min
        press(1, 1, 0, 8);              // mode wins over up
        check("prio_field", int'(bus.edit_field), 5);
        check("prio_min",   int'(bus.set_min), 0);
        press(1, 0, 0, 8);              // commit
        check("commit_cnt",    load_cnt, 1);
        check("commit_year",   ld[0], 2025);
        check("commit_month",  ld[1], 2);
        check("commit_day",    ld[2], 28);
        check("commit_hms",    ld[3] + ld[4] + ld[5], 0);
        check("commit_active", int'(bus.edit_active), 0);
        check("commit_field",  int'(bus.edit_field), 7);

        // out-of-range capture is normalised; year wraps both ways
        set_cur(1999, 13, 40, 25, 63, 60);
        press(1, 0, 0, 8);
        check("norm_year",  int'(bus.set_year), 2000);
        check("norm_month", int'(bus.set_month), 12);
        check("norm_day",   int'(bus.set_day), 31);
        check("norm_hour",  int'(bus.set_hour), 23);
        check("norm_min",   int'(bus.set_min), 59);
        check("norm_sec",   int'(bus.set_sec), 59);
        press(0, 0, 1, 8);
        check("year_wrap_dn", int'(bus.set_year), 2099);
        press(0, 1, 0, 8);
        check("year_wrap_up", int'(bus.set_year), 2000);
`ifdef AUTOREPEAT_EN
        press(0, 1, 0, 50);             // press + 4 repeats
        check("autorepeat_year", int'(bus.set_year), 2005);
`endif
        tick(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
